// File: rtl/bcd_seven_seg_scanner.sv
`default_nettype none
// ============================================================================
// Module  : bcd_seven_seg_scanner
// Brief   : Two-digit multiplexed seven-segment driver with per-frame sampling
//           and inter-digit blanking.
// Revision: 1.0 - initial release
// ============================================================================
module bcd_seven_seg_scanner #(
  parameter int REFRESH_DIV        = 50000,
  parameter int BLANK_CYCLES       = 2,
  parameter int COMMON_ANODE       = 1,
  parameter int BLANK_LEADING_ZERO = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] units_place,
  input  logic [3:0] tens_place,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       frame_tick
);

  localparam int c_MAX_DUR =
      (REFRESH_DIV > BLANK_CYCLES) ? ((REFRESH_DIV > 2) ? REFRESH_DIV : 2)
                                   : ((BLANK_CYCLES > 2) ? BLANK_CYCLES : 2);
  localparam int CW = $clog2(c_MAX_DUR);

  localparam logic [CW-1:0] c_REFRESH_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] c_BLANK_LAST   =
      (BLANK_CYCLES > 0) ? CW'(BLANK_CYCLES - 1) : '0;
  localparam logic c_HAS_GAP = (BLANK_CYCLES > 0);
  localparam logic c_INV     = (COMMON_ANODE != 0);
  localparam logic c_BLZ     = (BLANK_LEADING_ZERO != 0);

  typedef enum logic [2:0] {
    S_LOAD  = 3'd0,
    S_UNITS = 3'd1,
    S_GAP_A = 3'd2,
    S_TENS  = 3'd3,
    S_GAP_B = 3'd4
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [3:0]      r_units;
  logic [3:0]      r_tens;
  logic [6:0]      r_seg;
  logic [1:0]      r_an;
  logic            r_tick;

  state_t          w_state_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [3:0]      w_units_nxt;
  logic [3:0]      w_tens_nxt;
  logic [6:0]      w_seg_ah;
  logic [1:0]      w_an_ah;

  function automatic logic [6:0] f_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_LOAD:  w_state_nxt = S_UNITS;
      S_UNITS: if (r_cnt == c_REFRESH_LAST) w_state_nxt = c_HAS_GAP ? S_GAP_A : S_TENS;
      S_GAP_A: if (r_cnt == c_BLANK_LAST)   w_state_nxt = S_TENS;
      S_TENS:  if (r_cnt == c_REFRESH_LAST) w_state_nxt = c_HAS_GAP ? S_GAP_B : S_LOAD;
      S_GAP_B: if (r_cnt == c_BLANK_LAST)   w_state_nxt = S_LOAD;
      default: w_state_nxt = S_LOAD;
    endcase
    w_cnt_nxt = (w_state_nxt != r_state) ? '0 : r_cnt + 1'b1;
  end

  // Outputs are registered, so they are derived from the values the state
  // and shadow registers are about to take.
  always_comb begin
    w_units_nxt = (r_state == S_LOAD) ? units_place : r_units;
    w_tens_nxt  = (r_state == S_LOAD) ? tens_place  : r_tens;
    w_an_ah     = 2'b00;
    w_seg_ah    = 7'h00;
    case (w_state_nxt)
      S_UNITS: begin
        w_an_ah  = 2'b01;
        w_seg_ah = f_decode(w_units_nxt);
      end
      S_TENS: begin
        if (!(c_BLZ && (w_tens_nxt == 4'd0))) begin
          w_an_ah  = 2'b10;
          w_seg_ah = f_decode(w_tens_nxt);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_LOAD;
      r_cnt   <= '0;
      r_units <= 4'd0;
      r_tens  <= 4'd0;
      r_seg   <= {7{c_INV}};
      r_an    <= {2{c_INV}};
      r_tick  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_units <= w_units_nxt;
      r_tens  <= w_tens_nxt;
      r_seg   <= w_seg_ah ^ {7{c_INV}};
      r_an    <= w_an_ah ^ {2{c_INV}};
      r_tick  <= (w_state_nxt == S_LOAD);
    end
  end

  assign seg        = r_seg;
  assign an         = r_an;
  assign frame_tick = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_bcd_seven_seg_scanner.sv
`default_nettype none
// ============================================================================
// Module  : tb_bcd_seven_seg_scanner
// Brief   : Checks three scanner configurations against a frame-position model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_bcd_seven_seg_scanner;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] units_place = 4'd7;
  logic [3:0] tens_place = 4'd4;
  logic [6:0] seg0, seg1, seg2;
  logic [1:0] an0, an1, an2;
  logic       tick0, tick1, tick2;

  always #5 clk = ~clk;

  bcd_seven_seg_scanner #(.REFRESH_DIV(4), .BLANK_CYCLES(1), .COMMON_ANODE(1), .BLANK_LEADING_ZERO(1)) u_dut0 (
    .clk(clk), .reset(reset), .units_place(units_place), .tens_place(tens_place),
    .seg(seg0), .an(an0), .frame_tick(tick0));
  bcd_seven_seg_scanner #(.REFRESH_DIV(4), .BLANK_CYCLES(1), .COMMON_ANODE(0), .BLANK_LEADING_ZERO(0)) u_dut1 (
    .clk(clk), .reset(reset), .units_place(units_place), .tens_place(tens_place),
    .seg(seg1), .an(an1), .frame_tick(tick1));
  bcd_seven_seg_scanner #(.REFRESH_DIV(1), .BLANK_CYCLES(0), .COMMON_ANODE(1), .BLANK_LEADING_ZERO(1)) u_dut2 (
    .clk(clk), .reset(reset), .units_place(units_place), .tens_place(tens_place),
    .seg(seg2), .an(an2), .frame_tick(tick2));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  int         c_rd [3] = '{4, 4, 1};
  int         c_bc [3] = '{1, 1, 0};
  int         c_ca [3] = '{1, 0, 1};
  int         c_blz[3] = '{1, 0, 1};
  logic [6:0] dec_tab[16];
  int         k = 0;
  logic [3:0] m_u[3];
  logic [3:0] m_t[3];

  function automatic int frame_len(input int c);
    return 1 + 2 * c_rd[c] + 2 * c_bc[c];
  endfunction

  // k counts edges since reset release; frame position is simply k mod frame length.
  task automatic model_edge();
    if (reset) begin
      for (int c = 0; c < 3; c++) begin
        if ((k % frame_len(c)) == 0) begin
          m_u[c] = units_place;
          m_t[c] = tens_place;
        end
      end
      k++;
    end
  endtask

  task automatic model_reset();
    k = 0;
    for (int c = 0; c < 3; c++) begin
      m_u[c] = 4'd0;
      m_t[c] = 4'd0;
    end
  endtask

  task automatic check_all(input string tag);
    for (int c = 0; c < 3; c++) begin
      int         p;
      logic [6:0] s;
      logic [1:0] a;
      logic       t;
      logic [6:0] as;
      logic [1:0] aa;
      logic       at;
      p = k % frame_len(c);
      s = 7'h00;
      a = 2'b00;
      if (p >= 1 && p <= c_rd[c]) begin
        a = 2'b01;
        s = dec_tab[m_u[c]];
      end else if (p >= 1 + c_rd[c] + c_bc[c] && p <= 2 * c_rd[c] + c_bc[c]) begin
        if (!(c_blz[c] != 0 && m_t[c] == 4'd0)) begin
          a = 2'b10;
          s = dec_tab[m_t[c]];
        end
      end
      if (c_ca[c] != 0) begin
        s = ~s;
        a = ~a;
      end
      t = (p == 0) && (k > 0);
      case (c)
        0:       begin as = seg0; aa = an0; at = tick0; end
        1:       begin as = seg1; aa = an1; at = tick1; end
        default: begin as = seg2; aa = an2; at = tick2; end
      endcase
      chk($sformatf("%s.seg%0d", tag, c), 32'(as), 32'(s));
      chk($sformatf("%s.an%0d", tag, c), 32'(aa), 32'(a));
      chk($sformatf("%s.tick%0d", tag, c), 32'(at), 32'(t));
    end
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic async_reset(input int hold);
    #1 reset = 1'b0;
    model_reset();
    #1;
    chk("rst_async.an0", 32'(an0), 32'h3);
    chk("rst_async.seg0", 32'(seg0), 32'h7F);
    check_all("rst_async");
    repeat (hold) cycle("in_rst");
    reset = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) dec_tab[i] = 7'h40;
    dec_tab[0] = 7'h3F; dec_tab[1] = 7'h06; dec_tab[2] = 7'h5B; dec_tab[3] = 7'h4F;
    dec_tab[4] = 7'h66; dec_tab[5] = 7'h6D; dec_tab[6] = 7'h7D; dec_tab[7] = 7'h07;
    dec_tab[8] = 7'h7F; dec_tab[9] = 7'h6F;
    model_reset();

    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset.an0", 32'(an0), 32'h3);
    chk("reset.seg0", 32'(seg0), 32'h7F);
    chk("reset.tick0", 32'(tick0), 32'h0);
    chk("reset.an1", 32'(an1), 32'h0);
    check_all("reset");
    reset = 1'b1;

    repeat (33) cycle("first");

    tens_place = 4'd3; units_place = 4'd9;
    repeat (12) cycle("tear_a");
    for (int g = 0; g < 11 && (k % 11) != 2; g++) cycle("tear_align");
    tens_place = 4'd4; units_place = 4'd0;
    repeat (25) cycle("tear_b");

    tens_place = 4'd0; units_place = 4'd5;
    repeat (25) cycle("lead0");

    tens_place = 4'd15; units_place = 4'd12;
    repeat (25) cycle("invalid");

    tens_place = 4'd8; units_place = 4'd6;
    for (int g = 0; g < 11 && (k % 11) != 7; g++) cycle("tens_align");
    async_reset(2);
    repeat (15) cycle("post_rst");

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        units_place = 4'($urandom_range(0, 15));
        tens_place  = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 99) == 0) async_reset(int'($urandom_range(1, 3)));
      cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
